noc_packet_checker: RTL and testbench

Receive-end endpoint for the NoC test-traffic flow. It accepts flits from a router's local output port using a valid/ready handshake and reassembles header/payload/tail packets. For each packet it parses source and destination IDs, checks the header and tail markers, field consistency and the payload pattern, and reports a per-packet result with running packet and error counters. It sits beside the test sender nodes in mesh testbenches and doubles as a synthesizable self-check sink.

---
 rtl/noc_packet_checker_pkg.sv | 61 ++++++
 rtl/noc_packet_checker_flit_field_decode.sv | 20 ++
 rtl/noc_packet_checker.sv | 185 ++++++++++++++++++
 tb/tb_noc_packet_checker.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_packet_checker_pkg.sv
// Shared definitions for the NoC packet checker: flit field widths and bit
// positions, header/tail marker constants, FSM state type and pkt_err indices.
package noc_packet_checker_pkg;

  localparam int unsigned Noc_Data_Width  = 64;
  localparam int unsigned Noc_ID_X_Width  = 4;
  localparam int unsigned Noc_ID_Y_Width  = 4;
  localparam int unsigned Noc_Mark_Width  = 4;
  localparam int unsigned Noc_Type_Width  = 4;
  localparam int unsigned Noc_Order_Width = 8;
  localparam int unsigned Axi_Len_Width   = 8;

  // MSB position of each field, header layout MSB first
  localparam int unsigned Noc_Point_H      = Noc_Data_Width - 1;
  localparam int unsigned Noc_Source_Point = Noc_Point_H - Noc_Mark_Width;
  localparam int unsigned Noc_Dest_Point   = Noc_Source_Point - Noc_ID_X_Width - Noc_ID_Y_Width;
  localparam int unsigned Noc_Type_Point   = Noc_Dest_Point - Noc_ID_X_Width - Noc_ID_Y_Width;
  localparam int unsigned Noc_Order_Point  = Noc_Type_Point - Noc_Type_Width;
  localparam int unsigned Axi_Len_Point    = Noc_Order_Point - Noc_Order_Width;
  localparam int unsigned Noc_Point_E      = Axi_Len_Point - Axi_Len_Width;
  localparam int unsigned Noc_Pad_Width    = Noc_Point_E - Noc_Mark_Width + 1;

  // src/dst/TYPE/PACK_ORDER: the fields a tail must repeat from its header
  localparam int unsigned Noc_Ident_Width =
    2 * Noc_ID_X_Width + 2 * Noc_ID_Y_Width + Noc_Type_Width + Noc_Order_Width;

  localparam logic [Noc_Mark_Width-1:0] Noc_Head_H = 4'hA;
  localparam logic [Noc_Mark_Width-1:0] Noc_Head_E = 4'h5;
  localparam logic [Noc_Mark_Width-1:0] Noc_Tail_H = 4'hC;
  localparam logic [Noc_Mark_Width-1:0] Noc_Tail_E = 4'h3;

  localparam int unsigned Pkt_Err_Width = 5;
  localparam int unsigned ERR_DEST  = 0;
  localparam int unsigned ERR_MARK  = 1;
  localparam int unsigned ERR_TAIL  = 2;
  localparam int unsigned ERR_DATA  = 3;
  localparam int unsigned ERR_ABORT = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } chk_state_e;

  typedef struct packed {
    logic [Noc_Mark_Width-1:0]  h_mark;
    logic [Noc_ID_X_Width-1:0]  src_x;
    logic [Noc_ID_Y_Width-1:0]  src_y;
    logic [Noc_ID_X_Width-1:0]  dst_x;
    logic [Noc_ID_Y_Width-1:0]  dst_y;
    logic [Noc_Type_Width-1:0]  ptype;
    logic [Noc_Order_Width-1:0] pack_order;
    logic [Axi_Len_Width-1:0]   len;
    logic [Noc_Mark_Width-1:0]  e_mark;
    logic [Noc_Pad_Width-1:0]   pad;
  } noc_fields_t;

  function automatic logic [Noc_Ident_Width-1:0] flit_ident(input noc_fields_t f);
    return {f.src_x, f.src_y, f.dst_x, f.dst_y, f.ptype, f.pack_order};
  endfunction

endpackage

// File: rtl/noc_packet_checker_flit_field_decode.sv
// Combinational split of a header or tail flit into its fields.
module noc_flit_field_decode
  import noc_packet_checker_pkg::*;
(
  input  logic [Noc_Data_Width-1:0] flit,
  output noc_fields_t               fields
);

  assign fields.h_mark     = flit[Noc_Point_H -: Noc_Mark_Width];
  assign fields.src_x      = flit[Noc_Source_Point -: Noc_ID_X_Width];
  assign fields.src_y      = flit[Noc_Source_Point - Noc_ID_X_Width -: Noc_ID_Y_Width];
  assign fields.dst_x      = flit[Noc_Dest_Point -: Noc_ID_X_Width];
  assign fields.dst_y      = flit[Noc_Dest_Point - Noc_ID_X_Width -: Noc_ID_Y_Width];
  assign fields.ptype      = flit[Noc_Type_Point -: Noc_Type_Width];
  assign fields.pack_order = flit[Noc_Order_Point -: Noc_Order_Width];
  assign fields.len        = flit[Axi_Len_Point -: Axi_Len_Width];
  assign fields.e_mark     = flit[Noc_Point_E -: Noc_Mark_Width];
  assign fields.pad        = flit[Noc_Point_E - Noc_Mark_Width -: Noc_Pad_Width];

endmodule

// File: rtl/noc_packet_checker.sv
// NoC receive endpoint: reassembles header/payload/tail packets, checks them
// and reports a per-packet result plus running packet/error counters.
// Optional payload pattern check: define NOC_CHECK_DATA_PATTERN_EN.
module noc_packet_checker
  import noc_packet_checker_pkg::*;
#(
  parameter logic [Noc_ID_X_Width-1:0] X_ID        = '0,
  parameter logic [Noc_ID_Y_Width-1:0] Y_ID        = '0,
  parameter int unsigned               STALL_EVERY = 0
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst,
  input  logic                      receive_valid,
  output logic                      receive_ready,
  input  logic [Noc_Data_Width-1:0] receive_flit,
  input  logic                      receive_is_header,
  input  logic                      receive_is_tail,
  input  logic                      cnt_clear,
  output logic                      pkt_done,
  output logic [Pkt_Err_Width-1:0]  pkt_err,
  output logic [Noc_ID_X_Width-1:0] pkt_src_x,
  output logic [Noc_ID_Y_Width-1:0] pkt_src_y,
  output logic [7:0]                pkt_len,
  output logic                      stray_drop,
  output logic [15:0]               pkt_count,
  output logic [15:0]               err_count
);

  localparam logic [15:0] STALL_LAST = 16'(STALL_EVERY - 1);

  chk_state_e                 state, state_nxt;
  noc_fields_t                dec;
  logic                       accept;
  logic [Noc_Ident_Width-1:0] hdr_ident_q;
  logic [Pkt_Err_Width-1:0]   acc_err_q, hdr_err, rep_err_d;
  logic [7:0]                 len_q, rep_len_d;
  logic [Noc_ID_X_Width-1:0]  rep_sx_d;
  logic [Noc_ID_Y_Width-1:0]  rep_sy_d;
  logic                       rep_d, stray_d, start_hdr, add_payload;
  logic                       data_bad, tail_mark_bad, tail_mismatch;
  logic [15:0]                stall_cnt;
  logic                       unused_fields;

  noc_flit_field_decode u_decode (
    .flit   (receive_flit),
    .fields (dec)
  );

  assign accept        = receive_valid && receive_ready;
  assign unused_fields = ^{dec.len, dec.pad};
  assign tail_mark_bad = (dec.h_mark != Noc_Tail_H) || (dec.e_mark != Noc_Tail_E);
  assign tail_mismatch = (flit_ident(dec) != hdr_ident_q);

`ifdef NOC_CHECK_DATA_PATTERN_EN
  assign data_bad = (receive_flit != '1);
`else
  assign data_bad = 1'b0;
`endif

  // Errors detectable from the header flit alone
  always_comb begin
    hdr_err           = '0;
    hdr_err[ERR_DEST] = ({dec.dst_x, dec.dst_y} != {X_ID, Y_ID});
    hdr_err[ERR_MARK] = (dec.h_mark != Noc_Head_H) || (dec.e_mark != Noc_Head_E);
  end

  // State register
  always_ff @(posedge noc_clk) begin
    if (noc_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state: only an accepted flit moves the FSM
  always_comb begin
    state_nxt = state;
    if (accept) begin
      unique case (state)
        ST_IDLE:    if (receive_is_header && !receive_is_tail) state_nxt = ST_PAYLOAD;
        ST_PAYLOAD: if (receive_is_tail) state_nxt = ST_IDLE;
      endcase
    end
  end

  // Per-flit actions; a tail flag takes precedence over a header flag while a packet is open
  always_comb begin
    rep_d       = 1'b0;
    rep_err_d   = acc_err_q;
    rep_len_d   = len_q;
    rep_sx_d    = hdr_ident_q[Noc_Ident_Width-1 -: Noc_ID_X_Width];
    rep_sy_d    = hdr_ident_q[Noc_Ident_Width-Noc_ID_X_Width-1 -: Noc_ID_Y_Width];
    stray_d     = 1'b0;
    start_hdr   = 1'b0;
    add_payload = 1'b0;
    if (accept) begin
      unique case (state)
        ST_IDLE: begin
          if (receive_is_header && receive_is_tail) begin
            rep_d                = 1'b1;
            rep_err_d            = '0;
            rep_err_d[ERR_ABORT] = 1'b1;
            rep_err_d[ERR_TAIL]  = 1'b1;
            rep_len_d            = '0;
            rep_sx_d             = dec.src_x;
            rep_sy_d             = dec.src_y;
          end else if (receive_is_header) begin
            start_hdr = 1'b1;
          end else begin
            stray_d = 1'b1;
          end
        end
        ST_PAYLOAD: begin
          if (receive_is_tail) begin
            rep_d               = 1'b1;
            rep_err_d[ERR_MARK] = acc_err_q[ERR_MARK] | tail_mark_bad;
            rep_err_d[ERR_TAIL] = tail_mismatch;
          end else if (receive_is_header) begin
            rep_d                = 1'b1;
            rep_err_d[ERR_ABORT] = 1'b1;
            start_hdr            = 1'b1;
          end else begin
            add_payload = 1'b1;
          end
        end
      endcase
    end
  end

  // Open-packet bookkeeping and registered result outputs
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      hdr_ident_q <= '0;
      acc_err_q   <= '0;
      len_q       <= '0;
      pkt_done    <= 1'b0;
      pkt_err     <= '0;
      pkt_src_x   <= '0;
      pkt_src_y   <= '0;
      pkt_len     <= '0;
      stray_drop  <= 1'b0;
    end else begin
      pkt_done   <= rep_d;
      stray_drop <= stray_d;
      if (rep_d) begin
        pkt_err   <= rep_err_d;
        pkt_len   <= rep_len_d;
        pkt_src_x <= rep_sx_d;
        pkt_src_y <= rep_sy_d;
      end
      if (start_hdr) begin
        hdr_ident_q <= flit_ident(dec);
        acc_err_q   <= hdr_err;
        len_q       <= '0;
      end else if (add_payload) begin
        if (len_q != '1) len_q <= len_q + 8'd1;
        acc_err_q[ERR_DATA] <= acc_err_q[ERR_DATA] | data_bad;
      end
    end
  end

  // Packet and error counters; clear wins over a coincident increment
  always_ff @(posedge noc_clk) begin
    if (noc_rst || cnt_clear) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (rep_d) pkt_count <= pkt_count + 16'd1;
      if ((rep_d && (rep_err_d != '0)) || stray_d) err_count <= err_count + 16'd1;
    end
  end

  // Ready generation with one-cycle stall after every STALL_EVERY acceptances
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      receive_ready <= 1'b0;
      stall_cnt     <= '0;
    end else if ((STALL_EVERY != 0) && accept && (stall_cnt == STALL_LAST)) begin
      receive_ready <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      receive_ready <= 1'b1;
      if (accept) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_noc_packet_checker.sv
// Self-checking bench for noc_packet_checker: directed packets with literal
// expectations followed by randomized traffic against a packet-level model.
module tb_noc_packet_checker;

  localparam int unsigned N_STALL = 2;
  localparam logic [3:0]  MY_X = 4'd3;
  localparam logic [3:0]  MY_Y = 4'd0;
  localparam logic [3:0]  HH = 4'hA, HE = 4'h5, TH = 4'hC, TE = 4'h3;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef NOC_CHECK_DATA_PATTERN_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif

  typedef struct {
    bit          hd;
    bit          tl;
    logic [63:0] data;
    logic [3:0]  h, sx, sy, dx, dy, ty, e;
    logic [7:0]  ord, ln;
  } flit_t;

  logic        clk = 1'b0;
  logic        rst, vld, hd, tl, clr;
  logic [63:0] flit;
  logic        ready, done, stray;
  logic [4:0]  err;
  logic [3:0]  sx, sy;
  logic [7:0]  len;
  logic [15:0] pc, ec;

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  bit chk_en = 1'b0;
  bit want_clr = 1'b0;
  bit rnd_clr = 1'b0;

  // model state
  bit          m_open;
  logic [3:0]  m_sx, m_sy, m_dx, m_dy, m_ty;
  logic [7:0]  m_ord;
  logic [4:0]  m_err;
  int          m_len;
  int unsigned m_acc;
  bit          e_ready, e_done, e_stray;
  logic [4:0]  e_err;
  logic [3:0]  e_sx, e_sy;
  logic [7:0]  e_len;
  logic [15:0] e_pc, e_ec;
  bit          p_rst, p_acc, p_clr, last_acc;
  flit_t       p_f;

  always #5 clk = ~clk;

  noc_packet_checker #(
    .X_ID        (MY_X),
    .Y_ID        (MY_Y),
    .STALL_EVERY (N_STALL)
  ) dut (
    .noc_clk           (clk),
    .noc_rst           (rst),
    .receive_valid     (vld),
    .receive_ready     (ready),
    .receive_flit      (flit),
    .receive_is_header (hd),
    .receive_is_tail   (tl),
    .cnt_clear         (clr),
    .pkt_done          (done),
    .pkt_err           (err),
    .pkt_src_x         (sx),
    .pkt_src_y         (sy),
    .pkt_len           (len),
    .stray_drop        (stray),
    .pkt_count         (pc),
    .err_count         (ec)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic flit_t mk(bit h_f, bit t_f, logic [3:0] h, logic [3:0] s_x, logic [3:0] s_y,
                               logic [3:0] d_x, logic [3:0] d_y, logic [3:0] ty,
                               logic [7:0] ord, logic [7:0] ln, logic [3:0] e);
    flit_t f;
    f.hd = h_f; f.tl = t_f; f.h = h; f.e = e;
    f.sx = s_x; f.sy = s_y; f.dx = d_x; f.dy = d_y; f.ty = ty; f.ord = ord; f.ln = ln;
    f.data = {h, s_x, s_y, d_x, d_y, ty, ord, ln, e, 20'h5A5A5};
    return f;
  endfunction

  function automatic flit_t hdr(logic [3:0] s_x, logic [3:0] s_y, logic [3:0] d_x, logic [3:0] d_y);
    return mk(1'b1, 1'b0, HH, s_x, s_y, d_x, d_y, 4'h2, 8'h11, 8'h01, HE);
  endfunction

  function automatic flit_t tail(logic [3:0] s_x, logic [3:0] s_y, logic [3:0] d_x, logic [3:0] d_y);
    return mk(1'b0, 1'b1, TH, s_x, s_y, d_x, d_y, 4'h2, 8'h11, 8'h01, TE);
  endfunction

  function automatic flit_t pay(logic [63:0] d);
    flit_t f;
    f = mk(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 4'h0);
    f.data = d;
    return f;
  endfunction

  task automatic report(input logic [3:0] s_x, input logic [3:0] s_y, input int l, input logic [4:0] er);
    e_done = 1'b1; e_sx = s_x; e_sy = s_y; e_len = l[7:0]; e_err = er;
    e_pc++;
    if (er != 5'd0) e_ec++;
  endtask

  task automatic open_pkt(input flit_t f);
    m_open = 1'b1; m_len = 0; m_err = 5'd0;
    m_sx = f.sx; m_sy = f.sy; m_dx = f.dx; m_dy = f.dy; m_ty = f.ty; m_ord = f.ord;
    if (f.dx != MY_X || f.dy != MY_Y) m_err |= 5'b00001;
    if (f.h != HH || f.e != HE)       m_err |= 5'b00010;
  endtask

  // packet-level model: applies what the edge just consumed
  task automatic model_edge();
    logic [4:0] er;
    if (p_rst) begin
      m_open = 1'b0; m_acc = 0;
      e_ready = 1'b0; e_done = 1'b0; e_stray = 1'b0; e_err = '0;
      e_sx = '0; e_sy = '0; e_len = '0; e_pc = '0; e_ec = '0;
      return;
    end
    e_done = 1'b0; e_stray = 1'b0; e_ready = 1'b1;
    if (p_acc) begin
      m_acc++;
      if (m_acc % N_STALL == 0) e_ready = 1'b0;
      if (!m_open) begin
        if (p_f.hd && p_f.tl) report(p_f.sx, p_f.sy, 0, 5'b10100);
        else if (p_f.hd)      open_pkt(p_f);
        else begin e_stray = 1'b1; e_ec++; end
      end else if (p_f.tl) begin
        er = m_err;
        if (p_f.h != TH || p_f.e != TE) er |= 5'b00010;
        if ({p_f.sx, p_f.sy, p_f.dx, p_f.dy, p_f.ty, p_f.ord} != {m_sx, m_sy, m_dx, m_dy, m_ty, m_ord})
          er |= 5'b00100;
        report(m_sx, m_sy, m_len, er);
        m_open = 1'b0;
      end else if (p_f.hd) begin
        report(m_sx, m_sy, m_len, m_err | 5'b10000);
        open_pkt(p_f);
      end else begin
        if (m_len < 255) m_len++;
        if (PAT_EN && p_f.data != ONES) m_err |= 5'b01000;
      end
    end
    if (p_clr) begin e_pc = '0; e_ec = '0; end
  endtask

  task automatic cycle(input bit v, input flit_t f, input bit r);
    @(negedge clk);
    rst = r; vld = v; flit = f.data; hd = f.hd; tl = f.tl;
    clr = want_clr || (rnd_clr && $urandom_range(0, 39) == 0);
    want_clr = 1'b0;
    p_rst = r; p_acc = v && ready; p_clr = clr; p_f = f;
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    chk_en = 1'b1;
    last_acc = p_acc && !r;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, pay(64'h0), 1'b0);
  endtask

  task automatic rst_cyc();
    cycle(1'b0, pay(64'h0), 1'b1);
  endtask

  // present a flit and hold it until accepted, bounded
  task automatic send(input flit_t f);
    int unsigned w = 0;
    bit fin = 1'b0;
    while (!fin) begin
      cycle(1'b1, f, 1'b0);
      if (last_acc) fin = 1'b1;
      else begin
        w++;
        if (w > 6) begin
          total++; bad++;
          $display("FAIL accept_timeout: flit not taken after %0d cycles, required <= 1", w);
          fin = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [63:0] rnd_data();
    logic [63:0] d;
    d = ONES;
    if ($urandom_range(0, 4) == 0) d = {$urandom, $urandom};
    else if ($urandom_range(0, 4) == 0) d[$urandom_range(0, 63)] = 1'b0;
    return d;
  endfunction

  task automatic rand_pkt();
    int unsigned k = $urandom_range(0, 19);
    int unsigned np;
    logic [3:0] s_x = 4'($urandom), s_y = 4'($urandom), d_x = MY_X, d_y = MY_Y, ty = 4'($urandom);
    logic [7:0] ord = 8'($urandom), ln = 8'($urandom), tord;
    flit_t h, t;
    if ($urandom_range(0, 7) == 0) begin d_x = 4'($urandom); d_y = 4'($urandom); end
    idle($urandom_range(0, 2));
    if (k == 0) begin send(pay(rnd_data())); return; end
    h = mk(1'b1, 1'b0, ($urandom_range(0, 9) == 0) ? (HH ^ 4'h1) : HH, s_x, s_y, d_x, d_y, ty, ord, ln,
           ($urandom_range(0, 9) == 0) ? (HE ^ 4'h8) : HE);
    if (k == 1) begin h.tl = 1'b1; send(h); return; end
    send(h);
    np = $urandom_range(0, 4);
    for (int unsigned i = 0; i < np; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(pay(rnd_data()));
    end
    if (k == 2) return;
    if (k == 3) begin rst_cyc(); return; end
    tord = ($urandom_range(0, 7) == 0) ? (ord ^ 8'h01) : ord;
    t = mk(1'b0, 1'b1, ($urandom_range(0, 9) == 0) ? (TH ^ 4'h2) : TH, s_x, s_y, d_x, d_y, ty, tord,
           8'($urandom), ($urandom_range(0, 9) == 0) ? (TE ^ 4'h4) : TE);
    if (k == 4) t.hd = 1'b1;
    send(t);
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("receive_ready", {15'd0, ready}, {15'd0, e_ready});
      chk("pkt_done",      {15'd0, done},  {15'd0, e_done});
      chk("stray_drop",    {15'd0, stray}, {15'd0, e_stray});
      chk("pkt_err",       {11'd0, err},   {11'd0, e_err});
      chk("pkt_src",       {8'd0, sx, sy}, {8'd0, e_sx, e_sy});
      chk("pkt_len",       {8'd0, len},    {8'd0, e_len});
      chk("pkt_count",     pc, e_pc);
      chk("err_count",     ec, e_ec);
      if (done === 1'b1)
        $display("pkt_done src=(%0d,%0d) dst=(%0d,%0d) len=%0d err=%b", sx, sy, MY_X, MY_Y, len, err);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required finish before 900000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned c0;
    rst = 1'b1; vld = 1'b0; hd = 1'b0; tl = 1'b0; clr = 1'b0; flit = '0;
    rst_cyc(); rst_cyc();
    chk("rst_ready", {15'd0, ready}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_pkt_count", pc, 16'd0);
    idle(1);
    chk("ready_rise", {15'd0, ready}, 16'd1);

    // good packet from (1,2)
    send(hdr(1, 2, 3, 0)); send(pay(ONES)); send(tail(1, 2, 3, 0));
    chk("t1_done", {15'd0, done}, 16'd1);
    chk("t1_err", {11'd0, err}, 16'd0);
    chk("t1_len", {8'd0, len}, 16'd1);
    chk("t1_src", {8'd0, sx, sy}, 16'h0012);
    chk("t1_pkt_count", pc, 16'd1);

    // wrong destination
    send(hdr(1, 2, 2, 0)); send(pay(ONES)); send(tail(1, 2, 2, 0));
    chk("t2_err", {11'd0, err}, 16'd1);
    chk("t2_err_count", ec, 16'd1);

    // clear, then aborted packet followed by a good one
    want_clr = 1'b1; idle(1);
    chk("clr_pkt_count", pc, 16'd0);
    chk("clr_err_count", ec, 16'd0);
    send(hdr(1, 2, 3, 0)); send(pay(ONES)); send(hdr(2, 1, 3, 0));
    chk("t3a_done", {15'd0, done}, 16'd1);
    chk("t3a_err", {11'd0, err}, 16'h0010);
    chk("t3a_len", {8'd0, len}, 16'd1);
    chk("t3a_src", {8'd0, sx, sy}, 16'h0012);
    send(pay(ONES)); send(tail(2, 1, 3, 0));
    chk("t3b_err", {11'd0, err}, 16'd0);
    chk("t3b_src", {8'd0, sx, sy}, 16'h0021);
    chk("t3_pkt_count", pc, 16'd2);
    chk("t3_err_count", ec, 16'd1);

    // payload pattern mismatch
    send(hdr(1, 2, 3, 0)); send(pay(64'hFFFF_FFFF_FFFF_FFFE)); send(tail(1, 2, 3, 0));
    chk("t4_err", {11'd0, err}, PAT_EN ? 16'h0008 : 16'h0000);

    // stray payload in IDLE
    send(pay(ONES));
    chk("t5_stray", {15'd0, stray}, 16'd1);
    chk("t5_no_done", {15'd0, done}, 16'd0);
    chk("t5_err_count", ec, PAT_EN ? 16'd3 : 16'd2);

    // header+tail in one flit while IDLE
    send(mk(1'b1, 1'b1, HH, 4'd5, 4'd6, 4'd3, 4'd0, 4'h2, 8'h11, 8'h01, HE));
    chk("t5b_err", {11'd0, err}, 16'h0014);
    chk("t5b_len", {8'd0, len}, 16'd0);
    chk("t5b_pkt_count", pc, 16'd4);

    // stall pattern with valid held over 6 flits
    rst_cyc(); idle(1);
    c0 = cyc;
    send(hdr(7, 7, 3, 0));
    chk("stall_ready_1", {15'd0, ready}, 16'd1);
    send(pay(ONES));
    chk("stall_ready_2", {15'd0, ready}, 16'd0);
    send(pay(ONES)); send(pay(ONES));
    chk("stall_ready_4", {15'd0, ready}, 16'd0);
    send(pay(ONES)); send(tail(7, 7, 3, 0));
    chk("stall_cycles", 16'(cyc - c0), 16'd8);
    chk("stall_len", {8'd0, len}, 16'd4);
    chk("stall_err", {11'd0, err}, 16'd0);

    // length saturation
    send(hdr(1, 1, 3, 0));
    for (int unsigned i = 0; i < 257; i++) send(pay(ONES));
    send(tail(1, 1, 3, 0));
    chk("sat_len", {8'd0, len}, 16'd255);

    // reset in the middle of a packet
    send(hdr(1, 2, 3, 0)); send(pay(ONES));
    rst_cyc();
    chk("midrst_ready", {15'd0, ready}, 16'd0);
    chk("midrst_done", {15'd0, done}, 16'd0);
    chk("midrst_pkt_count", pc, 16'd0);
    chk("midrst_err_count", ec, 16'd0);
    idle(1);
    send(tail(1, 2, 3, 0));
    chk("midrst_tail_stray", {15'd0, stray}, 16'd1);

    // randomized traffic
    rnd_clr = 1'b1;
    for (int unsigned n = 0; n < 400; n++) rand_pkt();
    rnd_clr = 1'b0;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
